// File: rtl/accum_wr_sequencer_pkg.sv
// Shared helpers for the accumulator write sequencer.
// idx_w returns the bit width of an index over n entries, never below one bit.
// This keeps single-entry dimensions legal as port ranges.
package accum_wr_sequencer_pkg;

    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = int'($clog2(n));
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/accum_wr_sequencer.sv
// accum_wr_sequencer
//   Drives the write side of the accumulator table for one systolic-array output tile.
//   For each accepted start, the block first waits out the array fill latency.
//   It then issues SYS_ARR_ROWS write strobes with sub_row 0..ROWS-1.
//   The tile position stays constant for the whole tile.
//   A one-deep pending slot lets the next tile queue, so tiles write back-to-back.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        tile request, accepted when start && start_ready at a rising edge
//   submat_m_in  tile row position, sampled on acceptance
//   submat_n_in  tile col position, sampled on acceptance
//   flush        synchronous abort of the active and the pending tiles
//   start_ready  pending slot empty
//   busy         sequencer not idle
//   wr_en        write strobe for accumulator column 0
//   sub_row      row within the tile, valid while wr_en
//   submat_m/n   active tile position, held until the next tile enters fill
//   done         one-cycle pulse after the last write of a tile
module accum_wr_sequencer
    import accum_wr_sequencer_pkg::*;
#(
    parameter int unsigned SYS_ARR_ROWS = 32'd16,
    parameter int unsigned SYS_ARR_COLS = 32'd16,
    parameter int unsigned MAX_OUT_ROWS = 32'd128,
    parameter int unsigned MAX_OUT_COLS = 32'd128,
    parameter int unsigned FILL_LATENCY = 32'd16
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [idx_w(MAX_OUT_ROWS/SYS_ARR_ROWS)-1:0]      submat_m_in,
    input  logic [idx_w(MAX_OUT_COLS/SYS_ARR_COLS)-1:0]      submat_n_in,
    input  logic                                             flush,
    output logic                                             start_ready,
    output logic                                             busy,
    output logic                                             wr_en,
    output logic [idx_w(SYS_ARR_ROWS)-1:0]                   sub_row,
    output logic [idx_w(MAX_OUT_ROWS/SYS_ARR_ROWS)-1:0]      submat_m,
    output logic [idx_w(MAX_OUT_COLS/SYS_ARR_COLS)-1:0]      submat_n,
    output logic                                             done
);

    localparam int unsigned SR_W = idx_w(SYS_ARR_ROWS);
    localparam int unsigned M_W  = idx_w(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int unsigned N_W  = idx_w(MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int unsigned FC_W = idx_w(FILL_LATENCY);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [SR_W-1:0] LAST_ROW  = SR_W'(SYS_ARR_ROWS - 32'd1);
    localparam logic [SR_W-1:0] ROW_ZERO  = {SR_W{1'b0}};
    localparam logic [SR_W-1:0] ROW_ONE   = SR_W'(32'd1);
    localparam logic [FC_W-1:0] FILL_LOAD = FC_W'(FILL_LATENCY - 32'd1);
    localparam logic [FC_W-1:0] FC_ZERO   = {FC_W{1'b0}};
    localparam logic [FC_W-1:0] FC_ONE    = FC_W'(32'd1);

    logic [1:0]      state_r,      state_s;
    logic [FC_W-1:0] fill_cnt_r,   fill_cnt_s;
    logic [SR_W-1:0] sub_row_r,    sub_row_s;
    logic            pend_valid_r, pend_valid_s;
    logic [M_W-1:0]  pend_m_r,     pend_m_s;
    logic [N_W-1:0]  pend_n_r,     pend_n_s;
    logic [M_W-1:0]  submat_m_r,   submat_m_s;
    logic [N_W-1:0]  submat_n_r,   submat_n_s;
    logic            done_r,       done_s;
    logic            wr_en_r;
    logic            busy_r;
    logic            start_ready_r;
    logic            accept_s;

    // Next-state, counter and pending-slot logic; flush overrides everything including a same-cycle start
    always_comb begin
        state_s      = state_r;
        fill_cnt_s   = fill_cnt_r;
        sub_row_s    = sub_row_r;
        pend_valid_s = pend_valid_r;
        pend_m_s     = pend_m_r;
        pend_n_s     = pend_n_r;
        submat_m_s   = submat_m_r;
        submat_n_s   = submat_n_r;
        done_s       = 1'b0;
        accept_s     = start && start_ready_r;

        if (flush) begin
            state_s      = ST_IDLE;
            pend_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_valid_r) begin
                        state_s      = ST_FILL;
                        fill_cnt_s   = FILL_LOAD;
                        submat_m_s   = pend_m_r;
                        submat_n_s   = pend_n_r;
                        pend_valid_s = 1'b0;
                    end else if (accept_s) begin
                        // Acceptance from idle bypasses the pending slot
                        state_s    = ST_FILL;
                        fill_cnt_s = FILL_LOAD;
                        submat_m_s = submat_m_in;
                        submat_n_s = submat_n_in;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (fill_cnt_r == FC_ZERO) begin
                        state_s   = ST_WRITE;
                        sub_row_s = ROW_ZERO;
                    end else begin
                        fill_cnt_s = fill_cnt_r - FC_ONE;
                    end
                    if (accept_s) begin
                        pend_valid_s = 1'b1;
                        pend_m_s     = submat_m_in;
                        pend_n_s     = submat_n_in;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                end
                ST_WRITE: begin
                    sub_row_s = sub_row_r + ROW_ONE;
                    if (sub_row_r == LAST_ROW) begin
                        done_s = 1'b1;
                        if (pend_valid_r) begin
                            state_s      = ST_FILL;
                            fill_cnt_s   = FILL_LOAD;
                            submat_m_s   = pend_m_r;
                            submat_n_s   = pend_n_r;
                            pend_valid_s = 1'b0;
                        end else if (accept_s) begin
                            // Start in the final write cycle chains straight into fill
                            state_s    = ST_FILL;
                            fill_cnt_s = FILL_LOAD;
                            submat_m_s = submat_m_in;
                            submat_n_s = submat_n_in;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else if (accept_s) begin
                        pend_valid_s = 1'b1;
                        pend_m_s     = submat_m_in;
                        pend_n_s     = submat_n_in;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                end
                default: begin
                    state_s      = ST_IDLE;
                    pend_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, counters, pending slot and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            fill_cnt_r    <= FC_ZERO;
            sub_row_r     <= ROW_ZERO;
            pend_valid_r  <= 1'b0;
            pend_m_r      <= {M_W{1'b0}};
            pend_n_r      <= {N_W{1'b0}};
            submat_m_r    <= {M_W{1'b0}};
            submat_n_r    <= {N_W{1'b0}};
            done_r        <= 1'b0;
            wr_en_r       <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            fill_cnt_r    <= fill_cnt_s;
            sub_row_r     <= sub_row_s;
            pend_valid_r  <= pend_valid_s;
            pend_m_r      <= pend_m_s;
            pend_n_r      <= pend_n_s;
            submat_m_r    <= submat_m_s;
            submat_n_r    <= submat_n_s;
            done_r        <= done_s;
            wr_en_r       <= (state_s == ST_WRITE);
            busy_r        <= (state_s != ST_IDLE);
            start_ready_r <= !pend_valid_s;
        end
    end

    assign start_ready = start_ready_r;
    assign busy        = busy_r;
    assign wr_en       = wr_en_r;
    assign sub_row     = sub_row_r;
    assign submat_m    = submat_m_r;
    assign submat_n    = submat_n_r;
    assign done        = done_r;

endmodule

// File: tb/tb_accum_wr_sequencer.sv
// Self-checking bench for accum_wr_sequencer.
// The reference model describes each tile as a timeline relative to the cycle its fill begins.
// Writes occupy offsets FL..FL+ROWS-1 of that timeline.
// done follows in the cycle after the last write.
module tb_accum_wr_sequencer;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned MR   = 32;
    localparam int unsigned MC   = 32;
    localparam int unsigned FL   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       flush;
    logic [2:0] m_in;
    logic [2:0] n_in;
    logic       start_ready;
    logic       busy;
    logic       wr_en;
    logic [1:0] sub_row;
    logic [2:0] submat_m;
    logic [2:0] submat_n;
    logic       done;

    accum_wr_sequencer #(
        .SYS_ARR_ROWS(ROWS), .SYS_ARR_COLS(COLS),
        .MAX_OUT_ROWS(MR), .MAX_OUT_COLS(MC), .FILL_LATENCY(FL)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .submat_m_in(m_in), .submat_n_in(n_in), .flush(flush),
        .start_ready(start_ready), .busy(busy), .wr_en(wr_en),
        .sub_row(sub_row), .submat_m(submat_m), .submat_n(submat_n), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         cyc = 0;
    bit         act;
    int         t0;
    logic [2:0] cm, cn;
    bit         pv;
    logic [2:0] pm, pn;
    bit         exp_done;
    int         n_done, n_wr;
    logic [2:0] last_wm, last_wn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        act = 1'b0; pv = 1'b0; cm = 3'd0; cn = 3'd0;
        pm = 3'd0; pn = 3'd0; exp_done = 1'b0; t0 = 0;
    endtask

    // Applied at each rising edge, from the inputs the DUT sees at that edge
    task automatic model_edge();
        bit acc;
        bit nd;
        int off;
        acc = start && !pv;
        nd  = 1'b0;
        if (flush) begin
            act = 1'b0;
            pv  = 1'b0;
        end else if (act) begin
            off = cyc - t0;
            if (off == int'(FL + ROWS) - 1) begin
                nd = 1'b1;
                if (pv) begin
                    t0 = cyc + 1; cm = pm; cn = pn; pv = 1'b0;
                end else if (acc) begin
                    t0 = cyc + 1; cm = m_in; cn = n_in;
                end else begin
                    act = 1'b0;
                end
            end else if (acc) begin
                pv = 1'b1; pm = m_in; pn = n_in;
            end
        end else if (acc) begin
            act = 1'b1; t0 = cyc + 1; cm = m_in; cn = n_in;
        end
        exp_done = nd;
        cyc++;
    endtask

    task automatic check_outputs();
        int off;
        bit w;
        off = cyc - t0;
        w   = act && (off >= int'(FL));
        check("busy", 32'(busy), 32'(act));
        check("wr_en", 32'(wr_en), 32'(w));
        if (w) check("sub_row", 32'(sub_row), 32'(off - int'(FL)));
        check("submat_m", 32'(submat_m), 32'(cm));
        check("submat_n", 32'(submat_n), 32'(cn));
        check("start_ready", 32'(start_ready), 32'(!pv));
        check("done", 32'(done), 32'(exp_done));
        if (done === 1'b1) n_done++;
        if (wr_en === 1'b1) begin
            n_wr++; last_wm = submat_m; last_wn = submat_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic st, input logic fl, input logic [2:0] m, input logic [2:0] n);
        start = st; flush = fl; m_in = m; n_in = n;
    endtask

    task automatic clear_counts();
        n_done = 0; n_wr = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sub_row"}, 32'(sub_row), 32'd0);
        check({tag, "_m"}, 32'(submat_m), 32'd0);
        check({tag, "_n"}, 32'(submat_n), 32'd0);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    endtask

    task automatic idle_ticks(input int k);
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;

        // Single tile, m=3 n=5
        clear_counts();
        drive(1'b1, 1'b0, 3'd3, 3'd5); tick();
        idle_ticks(12);
        check("t2_dones", 32'(n_done), 32'd1);
        check("t2_writes", 32'(n_wr), 32'd4);
        check("t2_last_m", 32'(last_wm), 32'd3);
        check("t2_last_n", 32'(last_wn), 32'd5);

        // Queued second tile plus an ignored third request while the slot is full
        clear_counts();
        drive(1'b1, 1'b0, 3'd3, 3'd5); tick();
        idle_ticks(1);
        drive(1'b1, 1'b0, 3'd1, 3'd2); tick();
        drive(1'b1, 1'b0, 3'd6, 3'd7); tick(); tick();
        idle_ticks(20);
        check("t4_dones", 32'(n_done), 32'd2);
        check("t4_writes", 32'(n_wr), 32'd8);
        check("t4_last_m", 32'(last_wm), 32'd1);
        check("t4_last_n", 32'(last_wn), 32'd2);

        // Start in the last write cycle chains without a gap
        clear_counts();
        drive(1'b1, 1'b0, 3'd2, 3'd4); tick();
        idle_ticks(7);
        drive(1'b1, 1'b0, 3'd7, 3'd1); tick();
        idle_ticks(14);
        check("chain_dones", 32'(n_done), 32'd2);
        check("chain_writes", 32'(n_wr), 32'd8);

        // Flush in cycle 6 with a pending tile
        clear_counts();
        drive(1'b1, 1'b0, 3'd3, 3'd5); tick();
        idle_ticks(1);
        drive(1'b1, 1'b0, 3'd1, 3'd2); tick();
        idle_ticks(3);
        drive(1'b0, 1'b1, 3'd0, 3'd0); tick();
        idle_ticks(10);
        check("flush_dones", 32'(n_done), 32'd0);
        check("flush_writes", 32'(n_wr), 32'd2);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(start_ready), 32'd1);

        // start together with flush in idle
        clear_counts();
        drive(1'b1, 1'b1, 3'd4, 3'd4); tick();
        idle_ticks(10);
        check("sf_writes", 32'(n_wr), 32'd0);

        // Asynchronous reset in the middle of the write phase
        clear_counts();
        drive(1'b1, 1'b0, 3'd5, 3'd6); tick();
        idle_ticks(5);
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        #1 reset = 1'b1;
        idle_ticks(10);
        check("midrst_dones", 32'(n_done), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 40) == 0,
                  3'($urandom), 3'($urandom));
            tick();
        end
        idle_ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
